// File: rtl/lifo_stream_adapter_pkg.sv
// Shared types and constants for the LIFO stream adapter and its occupancy counter.
package lifo_pkg;

    localparam int DW_DEF    = 4;
    localparam int DEPTH_DEF = 8;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        CAPT = 2'd3
    } state_e;

endpackage

// File: rtl/lifo_stream_adapter_if.sv
// Push (valid/ready) and pop (request/valid) handshake bundle between producer/consumer and adapter.
interface lifo_stream_adapter_if #(
    parameter int DW = 4
);
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          pop_req;
    logic          pop_ready;
    logic          pop_valid;
    logic [DW-1:0] pop_data;

    modport master (
        output push_valid, push_data, pop_req,
        input  push_ready, pop_ready, pop_valid, pop_data
    );

    modport slave (
        input  push_valid, push_data, pop_req,
        output push_ready, pop_ready, pop_valid, pop_data
    );
endinterface

// File: rtl/lifo_stream_adapter_occ_cnt.sv
// Saturating up/down shadow occupancy counter (0..DEPTH) with synchronous active-low reset.
module lifo_occ_cnt #(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          Rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] MAX_CNT = CW'(DEPTH);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: saturate at both ends so the shadow count can never wrap.
    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != MAX_CNT)) begin
            count_d = count_q + CW'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!Rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lifo_stream_adapter.sv
// Handshake front-end driving a single-port LIFO stack (EN/RW/dataIn) and capturing its dataOut.
// Define LIFO_FLAG_CHECK_EN to compare the stack's EMPTY/FULL flags against the shadow count.
module lifo_stream_adapter
    import lifo_pkg::*;
#(
    parameter  int DW    = DW_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  Rst,
    lifo_stream_adapter_if.slave  s,
    output logic [DW-1:0]         lifo_dataIn,
    output logic                  lifo_RW,
    output logic                  lifo_EN,
    input  logic [DW-1:0]         lifo_dataOut,
    input  logic                  lifo_EMPTY,
    input  logic                  lifo_FULL,
    output logic [CW-1:0]         count,
    output logic                  err
);
    localparam logic [CW-1:0] MAX_CNT = CW'(DEPTH);

    state_e        state_q, state_d;
    logic          en_q, en_d;
    logic          rw_q, rw_d;
    logic [DW-1:0] din_q, din_d;
    logic          pv_q, pv_d;
    logic [DW-1:0] pd_q, pd_d;
    logic          err_q, err_d;
    logic          inc_s, dec_s;
    logic          push_acc_s, pop_acc_s;

    lifo_occ_cnt #(.DEPTH(DEPTH)) u_occ_cnt (
        .clk   (clk),
        .Rst   (Rst),
        .inc   (inc_s),
        .dec   (dec_s),
        .count (count)
    );

    assign s.push_ready = (state_q == IDLE) && (count < MAX_CNT);
    assign s.pop_ready  = (state_q == IDLE) && (count != '0);
    assign pop_acc_s    = s.pop_req && s.pop_ready;
    assign push_acc_s   = s.push_valid && s.push_ready && !pop_acc_s;

    // Next-state and registered-output logic; a pop wins over a simultaneous push.
    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        rw_d    = RW_WRITE;
        din_d   = din_q;
        pv_d    = 1'b0;
        pd_d    = pd_q;
        inc_s   = 1'b0;
        dec_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop_acc_s) begin
                    state_d = POP;
                    en_d    = 1'b1;
                    rw_d    = RW_READ;
                    dec_s   = 1'b1;
                end else if (push_acc_s) begin
                    state_d = PUSH;
                    en_d    = 1'b1;
                    din_d   = s.push_data;
                    inc_s   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            PUSH:    state_d = IDLE;
            POP:     state_d = CAPT;
            CAPT: begin
                pd_d    = lifo_dataOut;
                pv_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef LIFO_FLAG_CHECK_EN
    // Sticky error when the stack's flags disagree with the shadow count while idle.
    always_comb begin
        if ((state_q == IDLE) &&
            (((count == '0) != lifo_EMPTY) || ((count == MAX_CNT) != lifo_FULL))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end
`else
    logic unused_flags_s;
    assign unused_flags_s = lifo_EMPTY ^ lifo_FULL;
    assign err_d          = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!Rst) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            rw_q    <= RW_WRITE;
            din_q   <= '0;
            pv_q    <= 1'b0;
            pd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            din_q   <= din_d;
            pv_q    <= pv_d;
            pd_q    <= pd_d;
            err_q   <= err_d;
        end
    end

    assign lifo_EN     = en_q;
    assign lifo_RW     = rw_q;
    assign lifo_dataIn = din_q;
    assign s.pop_valid = pv_q;
    assign s.pop_data  = pd_q;
    assign err         = err_q;

endmodule

// File: tb/tb_lifo_stream_adapter.sv
// Bench for lifo_stream_adapter: directed plan plus random traffic against a transaction-level model.
module tb_lifo_stream_adapter;
    localparam int DW    = 4;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lifo_stream_adapter_if #(.DW(DW)) sif ();
    logic [DW-1:0] lifo_din, lifo_dout;
    logic          lifo_rw, lifo_en, lifo_empty, lifo_full;
    logic [CW-1:0] count;
    logic          err;

    lifo_stream_adapter #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .Rst          (rst_n),
        .s            (sif.slave),
        .lifo_dataIn  (lifo_din),
        .lifo_RW      (lifo_rw),
        .lifo_EN      (lifo_en),
        .lifo_dataOut (lifo_dout),
        .lifo_EMPTY   (lifo_empty),
        .lifo_FULL    (lifo_full),
        .count        (count),
        .err          (err)
    );

    // Stack environment: registered dataOut, pops/writes on EN.
    logic [DW-1:0] mem [DEPTH];
    int            sp;
    logic          bad_empty = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) begin
            sp        <= 0;
            lifo_dout <= '0;
        end else if (lifo_en) begin
            if (!lifo_rw && sp < DEPTH) begin
                mem[sp] <= lifo_din;
                sp      <= sp + 1;
            end else if (lifo_rw && sp > 0) begin
                lifo_dout <= mem[sp-1];
                sp        <= sp - 1;
            end
        end
    end
    assign lifo_empty = (sp == 0) ^ bad_empty;
    assign lifo_full  = (sp == DEPTH);

    // Transaction-level model.
    int            m_cnt, m_busy, m_pvcd;
    bit            m_pv, m_en, m_rw, m_err, prev_en;
    logic [DW-1:0] m_din, m_pd, m_pend;
    logic [DW-1:0] m_q [$];
    logic [DW-1:0] seen [$];
    int            checks = 0, passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_busy = 0; m_pvcd = 0; m_pv = 0; m_en = 0; m_rw = 0;
        m_err = 0; m_din = '0; m_pd = '0; m_pend = '0;
        m_q.delete();
    endtask

    task automatic step(input bit r, input bit pv, input logic [DW-1:0] pd, input bit pr);
        bit exp_push_rdy, exp_pop_rdy, acc_pop, acc_push;
        rst_n = r; sif.push_valid = pv; sif.push_data = pd; sif.pop_req = pr;
        #1;
        exp_push_rdy = (m_busy == 0) && (m_cnt < DEPTH);
        exp_pop_rdy  = (m_busy == 0) && (m_cnt != 0);
        chk("push_ready", 32'(sif.push_ready), 32'(exp_push_rdy));
        chk("pop_ready",  32'(sif.pop_ready),  32'(exp_pop_rdy));
        chk("count",      32'(count),          32'(m_cnt));
        chk("pop_valid",  32'(sif.pop_valid),  32'(m_pv));
        chk("pop_data",   32'(sif.pop_data),   32'(m_pd));
        chk("lifo_EN",    32'(lifo_en),        32'(m_en));
        chk("lifo_RW",    32'(lifo_rw),        32'(m_rw));
        chk("lifo_dataIn",32'(lifo_din),       32'(m_din));
        chk("err",        32'(err),            32'(m_err));
        chk("en_back_to_back", 32'(prev_en && lifo_en), 32'd0);
        prev_en = lifo_en;
        if (sif.pop_valid === 1'b1) seen.push_back(sif.pop_data);
        acc_pop  = exp_pop_rdy && pr;
        acc_push = exp_push_rdy && pv && !acc_pop;
        if (!r) begin
            model_reset();
        end else begin
`ifdef LIFO_FLAG_CHECK_EN
            if (m_busy == 0 && (((m_cnt == 0) != lifo_empty) || ((m_cnt == DEPTH) != lifo_full)))
                m_err = 1;
`endif
            m_pv = (m_pvcd == 1);
            if (m_pvcd == 1) m_pd = m_pend;
            m_pvcd = acc_pop ? 2 : (m_pvcd > 0 ? m_pvcd - 1 : 0);
            m_busy = acc_pop ? 2 : acc_push ? 1 : (m_busy > 0 ? m_busy - 1 : 0);
            m_en   = acc_pop || acc_push;
            m_rw   = acc_pop;
            if (acc_push) begin m_din = pd; m_cnt++; m_q.push_back(pd); end
            if (acc_pop)  begin m_pend = m_q.pop_back(); m_cnt--; end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        sif.push_valid = 1'b0; sif.push_data = '0; sif.pop_req = 1'b0;
        prev_en = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Pop requests at count 0 are ignored.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'h0, 1'b1);
        chk("empty_pop_count", 32'(count), 32'd0);
        chk("empty_pop_none", 32'(seen.size()), 32'd0);

        // Push 0,2,4,6 then pop four times: LIFO order.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 4'(2 * i), 1'b0);
            idle(1);
        end
        chk("count_after_4", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 4'h0, 1'b1);
            idle(3);
        end
        chk("pops_seen", 32'(seen.size()), 32'd4);
        if (seen.size() == 4) begin
            chk("pop0", 32'(seen[0]), 32'h6);
            chk("pop1", 32'(seen[1]), 32'h4);
            chk("pop2", 32'(seen[2]), 32'h2);
            chk("pop3", 32'(seen[3]), 32'h0);
        end
        chk("count_after_pops", 32'(count), 32'd0);

        // Fill to DEPTH, hold a 9th push, then free one slot.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b1, 4'(3 * i + 1), 1'b0);
            idle(1);
        end
        chk("full_count", 32'(count), 32'd8);
        chk("full_push_ready", 32'(sif.push_ready), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'h5, 1'b0);
        step(1'b1, 1'b1, 4'h5, 1'b1);
        idle(2);
        chk("after_pop_push_ready", 32'(sif.push_ready), 32'd1);
        chk("after_pop_count", 32'(count), 32'd7);

        // Simultaneous push and pop at count 3: pop first.
        step(1'b0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 4'(i + 10), 1'b0);
            idle(1);
        end
        step(1'b1, 1'b1, 4'h9, 1'b1);
        chk("both_rw_read", 32'(lifo_rw), 32'd1);
        chk("both_count", 32'(count), 32'd2);
        step(1'b1, 1'b1, 4'h9, 1'b0);
        step(1'b1, 1'b1, 4'h9, 1'b0);
        step(1'b1, 1'b1, 4'h9, 1'b0);
        chk("both_push_later", 32'(count), 32'd3);
        idle(1);

        // Reset during POP aborts the pop.
        seen.delete();
        step(1'b1, 1'b0, 4'h0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        chk("rst_pop_en", 32'(lifo_en), 32'd0);
        chk("rst_pop_count", 32'(count), 32'd0);
        idle(4);
        chk("rst_pop_no_valid", 32'(seen.size()), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) != 0), 1'($urandom_range(1)), 4'($urandom),
                 ($urandom_range(2) == 0));
        end

`ifdef LIFO_FLAG_CHECK_EN
        step(1'b0, 1'b0, 4'h0, 1'b0);
        bad_empty = 1'b1;
        idle(1);
        bad_empty = 1'b0;
        idle(2);
        chk("err_sticky", 32'(err), 32'd1);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        chk("err_cleared", 32'(err), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
